video_scandoubler: RTL

- Downstream of the ULA-style video generator. Converts its 15.6 kHz RGBI pixel stream into a line-doubled 31.2 kHz stream for VGA monitors.
- Captures each input line into one of two ping-pong line buffers, then replays the previous line twice at double pixel rate.
- Regenerates hsync/vsync/blank in the output domain. Single clock; the pixel rates are set by clock enables.

---
 rtl/video_pkg.sv | 33 +++
 rtl/scandoubler_linebuf.sv | 29 ++
 rtl/video_scandoubler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video constants and types for the ULA-style generator and scandoubler.
// Holds RGBI field positions, line-buffer sizing, pixel type and frame timing.
package video_pkg;

  localparam int RGBI_B = 0;
  localparam int RGBI_G = 1;
  localparam int RGBI_R = 2;
  localparam int RGBI_I = 3;

  localparam int H_TOTAL = 448;
  localparam int V_TOTAL = 312;

  localparam int LINE_MAX    = 512;
  localparam int DEFAULT_LEN = H_TOTAL;
  localparam int PTR_W       = $clog2(LINE_MAX);

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic blank;
    logic i;
    logic r;
    logic g;
    logic b;
  } pixel_t;

  localparam ptr_t PTR_MAX = ptr_t'(LINE_MAX - 1);

  function automatic ptr_t meas_len(ptr_t n);
    return (n == '0) ? ptr_t'(1) : n;
  endfunction

endpackage

// File: rtl/scandoubler_linebuf.sv
// Two-bank line buffer (2 x LINE_MAX x 5) for the scandoubler, block-RAM style.
// Ports: clock; write we/wbank/waddr/wdata; sync read re/rbank/raddr -> rdata.
module scandoubler_linebuf
  import video_pkg::*;
(
  input  logic             clock,
  input  logic             we,
  input  logic             wbank,
  input  logic [PTR_W-1:0] waddr,
  input  logic [4:0]       wdata,
  input  logic             re,
  input  logic             rbank,
  input  logic [PTR_W-1:0] raddr,
  output logic [4:0]       rdata
);

  logic [4:0] mem [2*LINE_MAX];

  always_ff @(posedge clock) begin
    if (we)
      mem[{wbank, waddr}] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (re)
      rdata <= mem[{rbank, raddr}];
  end

endmodule

// File: rtl/video_scandoubler.sv
// Line doubler: captures 15.6 kHz RGBI lines, replays each twice at 2x rate.
// Ports: clock/reset_n, ce_in/ce_out enables, rgbi/blank/hsync/vsync in and out.
module video_scandoubler
  import video_pkg::*;
#(
  parameter int HS_START = 0,
  parameter int HS_LEN   = 54
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_in,
  input  logic       ce_out,
  input  logic [3:0] rgbi_in,
  input  logic       blank_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [3:0] rgbi_out,
  output logic       blank_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  ptr_t   line_len;
  logic   bank;
  logic   valid;
  logic   seen;
  logic   hs_prev;
  logic   vld_q;

  logic   line_start;
  logic   we;
  logic   wr_bank;
  logic   rd_bank;
  logic   v_now;
  logic   hs_hit;
  ptr_t   meas;
  ptr_t   len_now;
  ptr_t   wr_idx;
  ptr_t   rd_idx;
  pixel_t wr_px;
  pixel_t rd_px;
  logic [4:0] rd_raw;

  assign line_start = ce_in & hsync_in & ~hs_prev;
  assign meas       = meas_len(wr_ptr);

  // On a line start the new bank/index/length apply to this
  // very cycle, so read and write never share a bank.
  assign len_now = line_start ? meas : line_len;
  assign wr_bank = line_start ? ~bank : bank;
  assign rd_bank = ~wr_bank;
  assign wr_idx  = line_start ? '0 : wr_ptr;
  assign rd_idx  = line_start ? '0 : rd_ptr;
  assign v_now   = line_start ? seen : valid;

  // Saturated pointer means the line overflowed: drop the rest.
  assign we = ce_in & (line_start | (wr_ptr != PTR_MAX));

  assign wr_px = '{
    blank: blank_in,
    i:     rgbi_in[RGBI_I],
    r:     rgbi_in[RGBI_R],
    g:     rgbi_in[RGBI_G],
    b:     rgbi_in[RGBI_B]
  };

  assign hs_hit =
    ptr_t'(rd_idx - ptr_t'(HS_START)) < ptr_t'(HS_LEN);

  scandoubler_linebuf u_buf (
    .clock (clock),
    .we    (we),
    .wbank (wr_bank),
    .waddr (wr_idx),
    .wdata (wr_px),
    .re    (ce_out),
    .rbank (rd_bank),
    .raddr (rd_idx),
    .rdata (rd_raw)
  );

  assign rd_px = pixel_t'(rd_raw);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      line_len  <= ptr_t'(DEFAULT_LEN);
      bank      <= 1'b0;
      valid     <= 1'b0;
      seen      <= 1'b0;
      hs_prev   <= 1'b0;
      vld_q     <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      if (ce_in) begin
        hs_prev <= hsync_in;
        wr_ptr  <= (wr_idx == PTR_MAX) ? PTR_MAX : wr_idx + 1'b1;
      end
      if (line_start) begin
        bank     <= ~bank;
        line_len <= meas;
        valid    <= seen;
        seen     <= 1'b1;
      end
      if (ce_out) begin
        rd_ptr    <= (rd_idx == len_now - 1'b1) ? '0 : rd_idx + 1'b1;
        vld_q     <= v_now;
        hsync_out <= hs_hit;
        if (rd_idx == '0)
          vsync_out <= vsync_in;
      end else if (line_start) begin
        rd_ptr <= '0;
      end
    end
  end

  assign rgbi_out  = (vld_q & ~rd_px.blank) ?
                     {rd_px.i, rd_px.r, rd_px.g, rd_px.b} : 4'h0;
  assign blank_out = rd_px.blank | ~vld_q;

endmodule
